matrix_stream_scheduler: RTL and testbench
==========================================

// Module: matrix_stream_scheduler
// PURPOSE
//  Round-robin scheduler sharing one downstream matrix-manipulation engine (diagonal,
//  triangular, ...) between NUM_REQ AXI-Stream requesters. Grants at whole-matrix granularity.
//  Forwards SIZE*SIZE beats through one output register stage and tags every beat with
//  source id, row, column and end-of-matrix tlast.
// PARAMETERS
//  SIZE        4   matrix dimension; matrix = SIZE*SIZE beats, row-major
//  DATA_WIDTH  32  element width
//  NUM_REQ     3   number of requesters, 2..8
//  ID_W        2   width of m_tid, >= clog2(NUM_REQ)
//  IDX_W       2   width of m_row/m_col, >= clog2(SIZE)
// PORTS
//  clk        in   1                   clock
//  rst        in   1                   synchronous reset, active-high
//  s_tdata    in   NUM_REQ*DATA_WIDTH  requester k data at [k*DATA_WIDTH +: DATA_WIDTH]
//  s_tvalid   in   NUM_REQ             per-requester valid
//  s_tready   out  NUM_REQ             per-requester ready, at most one bit high
//  m_tdata    out  DATA_WIDTH          element to engine, registered
//  m_tvalid   out  1                   output valid
//  m_tready   in   1                   engine ready
//  m_tlast    out  1                   high on element (SIZE-1,SIZE-1)
//  m_tid      out  ID_W                index of the requester that sourced the element
//  m_row      out  IDX_W               row of element, 0-based
//  m_col      out  IDX_W               column of element, 0-based
//  busy       out  1                   high while state==XFER
// BEHAVIOUR
//  - Reset (synchronous, active-high, rst; clock clk): state=IDLE; s_tready=0; m_tvalid=0;
//    m_tdata=0; m_tlast=0; m_tid=0; m_row=0; m_col=0; busy=0; rr pointer=0; row/col counters=0.
//  - FSM:
//    - IDLE -> XFER when any s_tvalid bit is set. Grant g = first requester with s_tvalid high,
//      searching from pointer upward and wrapping mod NUM_REQ. g is latched.
//    - XFER -> IDLE in the cycle the beat at row=SIZE-1, col=SIZE-1 is accepted.
//      pointer <= (g+1) mod NUM_REQ in the same cycle.
//  - s_tready[g] = (state==XFER) && (!m_tvalid || m_tready). All other s_tready bits are 0.
//    All s_tready bits are 0 in IDLE.
//  - Accepted beat (s_tvalid[g] && s_tready[g]):
//    - Next cycle m_tvalid=1 and m_tdata = the accepted element; m_tid=g; m_row/m_col = the
//      counter values; m_tlast = (row==SIZE-1 && col==SIZE-1).
//    - Counters then advance: col+1; at col==SIZE-1, col=0 and row+1; at the last element
//      both wrap to 0.
//  - Output register clears (m_tvalid=0) when m_tready=1 and no new beat is accepted.
//    All outputs hold stable while m_tvalid && !m_tready.
//  - Latency: s_tvalid seen in IDLE at cycle 0 -> s_tready[g] at cycle 1 -> first m_tvalid at
//    cycle 2. Steady state is 1 beat/cycle with 1-cycle pass latency.
//  - No preemption. The grant holds for the full matrix even if s_tvalid[g] drops mid-matrix;
//    counters freeze until the requester resumes.
//  - The last output beat may still be pending in IDLE. The next grant proceeds, but no beat
//    is accepted until the register frees. Back-to-back matrices cost exactly 1 IDLE cycle.
//  - Simultaneous requests: round-robin ordering from the pointer, so no requester starves.
//  - Reset mid-matrix: partial matrix is dropped, counters and pointer return to 0, and no
//    m_tlast is emitted for it.
// CONFIGURATION
//  - MATSCHED_STATS_EN defined: adds output port mat_count (16 bits, reset 0). It increments
//    when an m_tlast beat completes (m_tvalid && m_tready && m_tlast) and wraps 0xFFFF->0.
//  - MATSCHED_STATS_EN not defined: port and counter are absent; all other behaviour is identical.
// TESTING (SIZE=4, NUM_REQ=3, DATA_WIDTH=32)
//  1. Reset, then req1 streams 1..16 with m_tready=1 -> first m_tvalid 2 cycles after s_tvalid;
//     16 beats with m_tid=1; (row,col) (0,0)..(3,3); m_tlast only on data 16.
//  2. All three s_tvalid high continuously after reset -> matrices granted in order 0,1,2,0;
//     exactly 1 idle cycle between matrices; s_tready one-hot.
//  3. m_tready low for 5 cycles at beat 7 -> m_tdata=7 held stable; s_tready[g]=0 during stall;
//     no beat lost or duplicated; order 1..16 preserved.
//  4. Granted requester drops s_tvalid after beat 9 for 4 cycles while req2 is valid -> no
//     switch; beat 10 resumes at (2,1); req2 granted only after (3,3).
//  5. rst asserted at beat 6 of req0 -> next cycle all outputs 0, state IDLE; next matrix
//     starts at (0,0) and is granted to req0.
//  6. MATSCHED_STATS_EN defined, 3 matrices completed -> mat_count=3; rst -> mat_count=0.

Source files
------------

// File: rtl/matrix_stream_if.sv
// Bundle of the requester-side and engine-side AXI-Stream signals of the
// matrix stream scheduler. The master modport is the scheduler's view, the
// slave modport is the environment (requesters plus engine).
interface matrix_stream_if #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ID_W       = 2,
   parameter int IDX_W      = 2
);
   logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata;
   logic [NUM_REQ-1:0]            s_tvalid;
   logic [NUM_REQ-1:0]            s_tready;
   logic [DATA_WIDTH-1:0]         m_tdata;
   logic                          m_tvalid;
   logic                          m_tready;
   logic                          m_tlast;
   logic [ID_W-1:0]               m_tid;
   logic [IDX_W-1:0]              m_row;
   logic [IDX_W-1:0]              m_col;

   modport master (
      input  s_tdata, s_tvalid, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tlast, m_tid, m_row, m_col
   );

   modport slave (
      output s_tdata, s_tvalid, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid, m_row, m_col
   );
endinterface

// File: rtl/matrix_stream_scheduler.sv
// Round-robin scheduler sharing one matrix engine between NUM_REQ
// AXI-Stream requesters. A grant covers a whole SIZE*SIZE matrix; every
// forwarded beat passes one output register and carries source id, row,
// column and an end-of-matrix tlast.
// Optional feature: define MATSCHED_STATS_EN to add the 16-bit mat_count
// port counting completed matrices.
module matrix_stream_scheduler #(
   parameter int SIZE       = 4,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 3,
   parameter int ID_W       = 2,
   parameter int IDX_W      = 2
) (
   input  logic              clk,
   input  logic              rst,
   matrix_stream_if.master   bus,
   output logic              busy
`ifdef MATSCHED_STATS_EN
   ,
   output logic [15:0]       mat_count
`endif
);

   typedef enum logic [0:0] {IDLE, XFER} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
   localparam logic [ID_W-1:0]  LAST_REQ = ID_W'(NUM_REQ - 1);

   state_t                state_reg;
   logic                  busy_reg;
   logic [ID_W-1:0]       grant_reg;
   logic [ID_W-1:0]       ptr_reg;
   logic [IDX_W-1:0]      row_reg;
   logic [IDX_W-1:0]      col_reg;

   logic [DATA_WIDTH-1:0] m_tdata_reg;
   logic                  m_tvalid_reg;
   logic                  m_tlast_reg;
   logic [ID_W-1:0]       m_tid_reg;
   logic [IDX_W-1:0]      m_row_reg;
   logic [IDX_W-1:0]      m_col_reg;

   logic [ID_W-1:0]       pick_next;
   logic [ID_W-1:0]       ptr_next;
   logic [NUM_REQ-1:0]    ready_vec;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  out_free;
   logic                  xfer_ready;
   logic                  accept;
   logic                  last_elem;

   // Round-robin pick: lowest valid index at or above the pointer wins;
   // otherwise the lowest valid index below it (the wrapped part).
   always_comb begin
      pick_next = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.s_tvalid[k] && (ID_W'(k) < ptr_reg))
            pick_next = ID_W'(k);
      end
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.s_tvalid[k] && (ID_W'(k) >= ptr_reg))
            pick_next = ID_W'(k);
      end
   end

   // Data mux from the granted requester.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_reg == ID_W'(k))
            sel_data = bus.s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // The output register can take a new beat when empty or draining this cycle.
   assign out_free   = !m_tvalid_reg || bus.m_tready;
   assign xfer_ready = (state_reg == XFER) && out_free;
   assign last_elem  = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);
   assign ptr_next   = (grant_reg == LAST_REQ) ? '0 : grant_reg + ID_W'(1);

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign ready_vec[gi] = xfer_ready && (grant_reg == ID_W'(gi));
      end
   endgenerate

   assign accept = |(bus.s_tvalid & ready_vec);

   // Grant FSM: latch the winner in IDLE, count the matrix out in XFER.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         busy_reg  <= 1'b0;
         grant_reg <= '0;
         ptr_reg   <= '0;
         row_reg   <= '0;
         col_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|bus.s_tvalid) begin
                  state_reg <= XFER;
                  busy_reg  <= 1'b1;
                  grant_reg <= pick_next;
               end
            end
            XFER: begin
               if (accept) begin
                  if (last_elem) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                     ptr_reg   <= ptr_next;
                     row_reg   <= '0;
                     col_reg   <= '0;
                  end else if (col_reg == LAST_IDX) begin
                     col_reg <= '0;
                     row_reg <= row_reg + IDX_W'(1);
                  end else begin
                     col_reg <= col_reg + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Output register: load on accept, empty when drained, hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_tdata_reg  <= '0;
         m_tvalid_reg <= 1'b0;
         m_tlast_reg  <= 1'b0;
         m_tid_reg    <= '0;
         m_row_reg    <= '0;
         m_col_reg    <= '0;
      end else if (accept) begin
         m_tdata_reg  <= sel_data;
         m_tvalid_reg <= 1'b1;
         m_tlast_reg  <= last_elem;
         m_tid_reg    <= grant_reg;
         m_row_reg    <= row_reg;
         m_col_reg    <= col_reg;
      end else if (bus.m_tready) begin
         m_tvalid_reg <= 1'b0;
      end
   end

   assign bus.s_tready = ready_vec;
   assign bus.m_tdata  = m_tdata_reg;
   assign bus.m_tvalid = m_tvalid_reg;
   assign bus.m_tlast  = m_tlast_reg;
   assign bus.m_tid    = m_tid_reg;
   assign bus.m_row    = m_row_reg;
   assign bus.m_col    = m_col_reg;
   assign busy         = busy_reg;

`ifdef MATSCHED_STATS_EN
   logic [15:0] mat_count_reg;

   // Count matrices whose final beat the engine has taken; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst)
         mat_count_reg <= '0;
      else if (m_tvalid_reg && bus.m_tready && m_tlast_reg)
         mat_count_reg <= mat_count_reg + 16'd1;
   end

   assign mat_count = mat_count_reg;
`endif

endmodule

// File: tb/tb_matrix_stream_scheduler.sv
// Directed bench for matrix_stream_scheduler (SIZE=4, NUM_REQ=3, DATA_WIDTH=32).
// A per-requester counter model feeds the inputs; a monitor records every
// beat the engine takes; expectations come from a row-major table.
module tb_matrix_stream_scheduler;
   localparam int SIZE = 4;
   localparam int DW   = 32;
   localparam int NR   = 3;
   localparam int ID_W = 2;
   localparam int IDXW = 2;

   logic clk;
   logic rst;
   logic busy;
`ifdef MATSCHED_STATS_EN
   logic [15:0] mat_count;
`endif

   matrix_stream_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_W(ID_W), .IDX_W(IDXW)) bus ();

   matrix_stream_scheduler #(
      .SIZE(SIZE), .DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(ID_W), .IDX_W(IDXW)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
`ifdef MATSCHED_STATS_EN
      ,
      .mat_count (mat_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int data;
      int row;
      int col;
      bit last;
   } vec_t;

   typedef struct {
      logic [47:0] key;
      int          cyc;
      bit          last;
   } beat_t;

   vec_t  tv [16];
   beat_t out_q [$];

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int first_v;
   int onehot_err;

   // requester model state
   bit en [NR];
   int next_val [NR];
   int remain [NR];
   int sent [NR];
   int stall_after [NR];
   int stall_len [NR];
   int hold [NR];
   bit rdy;

   // values sampled on the falling edge
   logic          samp_mvalid, samp_mlast, samp_busy;
   logic [DW-1:0] samp_mdata;
   logic [ID_W-1:0] samp_tid;
   logic [IDXW-1:0] samp_row, samp_col;
   logic [NR-1:0] samp_sready;
`ifdef MATSCHED_STATS_EN
   logic [15:0]   samp_count;
`endif

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      else
         passed++;
   endfunction

   function automatic logic [47:0] pack(int tid, int row, int col, bit last, int data);
      return {4'(tid), 4'(row), 4'(col), 4'(last), 32'(data)};
   endfunction

   // One clock: drive inputs, sample mid-cycle, then apply handshakes.
   task automatic step();
      logic [NR-1:0]    vdrv;
      logic [NR*DW-1:0] ddrv;
      logic [NR-1:0]    fire;
      for (int k = 0; k < NR; k++) begin
         logic v;
         v = en[k] && (remain[k] > 0);
         if (v && hold[k] > 0) begin
            v = 1'b0;
            hold[k]--;
         end
         vdrv[k] = v;
         ddrv[k*DW +: DW] = 32'(next_val[k]);
      end
      bus.s_tvalid = vdrv;
      bus.s_tdata  = ddrv;
      bus.m_tready = rdy;
      @(negedge clk);
      samp_mvalid = bus.m_tvalid;
      samp_mdata  = bus.m_tdata;
      samp_mlast  = bus.m_tlast;
      samp_tid    = bus.m_tid;
      samp_row    = bus.m_row;
      samp_col    = bus.m_col;
      samp_busy   = busy;
      samp_sready = bus.s_tready;
`ifdef MATSCHED_STATS_EN
      samp_count  = mat_count;
`endif
      fire = bus.s_tvalid & bus.s_tready;
      if ((samp_sready & (samp_sready - 1'b1)) != '0) onehot_err++;
      if (samp_mvalid && first_v < 0) first_v = cyc;
      if (samp_mvalid && rdy) begin
         out_q.push_back('{pack(int'(samp_tid), int'(samp_row), int'(samp_col),
                               samp_mlast, int'(samp_mdata)), cyc, samp_mlast});
         if (samp_mlast)
            $display("matrix done: tid=%0d last_data=%0d cycle=%0d", samp_tid, samp_mdata, cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < NR; k++) begin
         if (fire[k]) begin
            next_val[k]++;
            remain[k]--;
            sent[k]++;
            if (sent[k] == stall_after[k]) hold[k] = stall_len[k];
         end
      end
   endtask

   task automatic load(int k, int base, int n);
      next_val[k] = base;
      remain[k] = n;
      sent[k] = 0;
      stall_after[k] = -1;
      stall_len[k] = 0;
      hold[k] = 0;
      en[k] = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rdy = 1'b1;
      for (int k = 0; k < NR; k++) en[k] = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Step until requesters are drained and the output is empty, bounded.
   task automatic run_drain(string name, int maxc);
      bit done;
      done = 1'b0;
      for (int n = 0; n < maxc && !done; n++) begin
         step();
         done = !samp_busy && !samp_mvalid;
         for (int k = 0; k < NR; k++)
            if (en[k] && remain[k] > 0) done = 1'b0;
      end
      chk({name, "_drained"}, 64'(done), 64'd1);
   endtask

   task automatic check_matrix(string name, int base_idx, int tid, int dbase);
      for (int i = 0; i < 16; i++) begin
         if (base_idx + i < out_q.size())
            chk($sformatf("%s_beat%0d", name, i), 64'(out_q[base_idx + i].key),
                64'(pack(tid, tv[i].row, tv[i].col, tv[i].last, dbase + tv[i].data)));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int nlast;

      // row-major element table: offset, row, col, tlast
      for (int i = 0; i < 16; i++)
         tv[i] = '{i, i / SIZE, i % SIZE, (i == 15)};

      for (int k = 0; k < NR; k++) begin
         en[k] = 1'b0; remain[k] = 0; next_val[k] = 0; sent[k] = 0;
         stall_after[k] = -1; stall_len[k] = 0; hold[k] = 0;
      end
      first_v = -1;
      onehot_err = 0;
      bus.s_tvalid = '0;
      bus.s_tdata = '0;
      bus.m_tready = 1'b1;

      // Test 1: reset values, then req1 streams 1..16
      do_reset();
      step();
      chk("rst_mvalid", 64'(samp_mvalid), 64'd0);
      chk("rst_mdata",  64'(samp_mdata),  64'd0);
      chk("rst_mlast",  64'(samp_mlast),  64'd0);
      chk("rst_tid",    64'(samp_tid),    64'd0);
      chk("rst_row",    64'(samp_row),    64'd0);
      chk("rst_col",    64'(samp_col),    64'd0);
      chk("rst_busy",   64'(samp_busy),   64'd0);
      chk("rst_sready", 64'(samp_sready), 64'd0);
      out_q.delete();
      first_v = -1;
      load(1, 1, 16);
      c0 = cyc;
      run_drain("t1", 100);
      chk("t1_latency", 64'(first_v - c0), 64'd2);
      chk("t1_nbeats", 64'(out_q.size()), 64'd16);
      check_matrix("t1", 0, 1, 1);
      if (out_q.size() == 16)
         chk("t1_rate", 64'(out_q[15].cyc - out_q[0].cyc), 64'd15);

      // Test 2: all requesters busy, round-robin 0,1,2,0 with one bubble
      do_reset();
      out_q.delete();
      onehot_err = 0;
      load(0, 0, 32);
      load(1, 1000, 16);
      load(2, 2000, 16);
      run_drain("t2", 300);
      chk("t2_nbeats", 64'(out_q.size()), 64'd64);
      check_matrix("t2_m0", 0, 0, 0);
      check_matrix("t2_m1", 16, 1, 1000);
      check_matrix("t2_m2", 32, 2, 2000);
      check_matrix("t2_m3", 48, 0, 16);
      if (out_q.size() == 64)
         for (int m = 1; m < 4; m++)
            chk($sformatf("t2_gap%0d", m), 64'(out_q[16*m].cyc - out_q[16*m-1].cyc), 64'd2);
      chk("t2_onehot", 64'(onehot_err), 64'd0);

      // Test 3: engine stalls 5 cycles while beat 7 is on the output
      do_reset();
      out_q.delete();
      load(1, 1, 16);
      c0 = cyc;
      for (int n = 0; n < 8; n++) step();
      rdy = 1'b0;
      for (int n = 0; n < 5; n++) begin
         step();
         chk($sformatf("t3_hold_valid%0d", n), 64'(samp_mvalid), 64'd1);
         chk($sformatf("t3_hold_data%0d", n), 64'(samp_mdata), 64'd7);
         chk($sformatf("t3_stall_sready%0d", n), 64'(samp_sready), 64'd0);
      end
      rdy = 1'b1;
      run_drain("t3", 100);
      chk("t3_nbeats", 64'(out_q.size()), 64'd16);
      check_matrix("t3", 0, 1, 1);

      // Test 4: granted req1 pauses 4 cycles after beat 9, req2 waits
      do_reset();
      out_q.delete();
      load(1, 1, 16);
      stall_after[1] = 9;
      stall_len[1] = 4;
      load(2, 5000, 16);
      run_drain("t4", 200);
      chk("t4_nbeats", 64'(out_q.size()), 64'd32);
      check_matrix("t4_req1", 0, 1, 1);
      check_matrix("t4_req2", 16, 2, 5000);
      if (out_q.size() == 32)
         chk("t4_pause_gap", 64'(out_q[9].cyc - out_q[8].cyc), 64'd5);

      // Test 5: move the pointer, then reset in the middle of a req0 matrix
      out_q.delete();
      load(1, 1, 16);
      run_drain("t5_pre", 100);
      out_q.delete();
      load(0, 100, 16);
      for (int n = 0; n < 6; n++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      en[0] = 1'b0;
      step();
      chk("t5_mvalid", 64'(samp_mvalid), 64'd0);
      chk("t5_mdata",  64'(samp_mdata),  64'd0);
      chk("t5_tid",    64'(samp_tid),    64'd0);
      chk("t5_rowcol", 64'({samp_row, samp_col}), 64'd0);
      chk("t5_mlast",  64'(samp_mlast),  64'd0);
      chk("t5_busy",   64'(samp_busy),   64'd0);
      chk("t5_sready", 64'(samp_sready), 64'd0);
      nlast = 0;
      foreach (out_q[i]) if (out_q[i].last) nlast++;
      chk("t5_no_tlast", 64'(nlast), 64'd0);
      out_q.delete();
      load(0, 200, 16);
      load(2, 300, 16);
      run_drain("t5", 200);
      chk("t5_nbeats", 64'(out_q.size()), 64'd32);
      check_matrix("t5_req0", 0, 0, 200);
      check_matrix("t5_req2", 16, 2, 300);

`ifdef MATSCHED_STATS_EN
      // Test 6: completed-matrix counter
      do_reset();
      load(0, 0, 16);
      load(1, 0, 16);
      load(2, 0, 16);
      run_drain("t6", 200);
      chk("t6_count", 64'(samp_count), 64'd3);
      do_reset();
      step();
      chk("t6_count_rst", 64'(samp_count), 64'd0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
